// File: rtl/barret_2677_rr_scheduler.sv
// barret_2677_rr_scheduler: round-robin access to a shared Barrett mod-2677 reducer
// through an operand stage (S1) and a result stage (S2) with valid/ready on both sides.
module barret_2677_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int DIN_W   = 23,
   parameter int DOUT_W  = 12,
   parameter int Q       = 2677,
   parameter int QSQ_MAX = 7166328
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*DIN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DOUT_W-1:0]        rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_err,
   output logic                     busy,
   output logic [15:0]              op_cnt
);
   // 2^34/Q keeps the quotient estimate within one of exact for 23-bit operands
   localparam int          K = 34;
   localparam logic [63:0] M = (64'd1 << K) / 64'(Q);

   logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [DIN_W-1:0]  s1_data_q, s1_data_d;
   logic [ID_W-1:0]   s1_id_q, s1_id_d, s2_id_q, s2_id_d;
   logic [DOUT_W-1:0] s2_data_q, s2_data_d;
   logic              s2_err_q, s2_err_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]       op_cnt_q, op_cnt_d;

   logic              s2_free, s1_free, s1_move, accept, gnt_vld;
   logic [ID_W-1:0]   gnt_id, idx;
   logic [63:0]       prod;
   logic [31:0]       q_est, r_raw, r_fix;
   logic              red_err;

   // descending scan so the lowest offset from rr_ptr wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   always_comb begin
      prod    = 64'(s1_data_q) * M;
      q_est   = 32'(prod >> K);
      r_raw   = 32'(s1_data_q) - q_est * 32'(Q);
      r_fix   = (r_raw >= 32'(Q)) ? r_raw - 32'(Q) : r_raw;
      red_err = 32'(s1_data_q) > 32'(QSQ_MAX);
   end

   always_comb begin
      s2_free    = !s2_valid_q || rsp_ready;
      s1_free    = !s1_valid_q || s2_free;
      s1_move    = s1_valid_q && s2_free;
      accept     = s1_free && gnt_vld;
      req_ready  = accept ? (NUM_REQ'(1) << gnt_id) : '0;
      rr_ptr_d   = accept ? ((int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
      op_cnt_d   = op_cnt_q + 16'(accept);
      s1_valid_d = accept ? 1'b1 : (s1_move ? 1'b0 : s1_valid_q);
      s1_data_d  = accept ? req_data[int'(gnt_id)*DIN_W +: DIN_W] : s1_data_q;
      s1_id_d    = accept ? gnt_id : s1_id_q;
      s2_valid_d = s1_move ? 1'b1 : (rsp_ready ? 1'b0 : s2_valid_q);
      s2_data_d  = s1_move ? (red_err ? '0 : DOUT_W'(r_fix)) : s2_data_q;
      s2_id_d    = s1_move ? s1_id_q : s2_id_q;
      s2_err_d   = s1_move ? red_err : s2_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_id_q    <= '0;
         s2_err_q   <= 1'b0;
         rr_ptr_q   <= '0;
         op_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_id_q    <= s2_id_d;
         s2_err_q   <= s2_err_d;
         rr_ptr_q   <= rr_ptr_d;
         op_cnt_q   <= op_cnt_d;
      end
   end

   assign rsp_valid = s2_valid_q;
   assign rsp_data  = s2_data_q;
   assign rsp_id    = s2_id_q;
   assign rsp_err   = s2_err_q;
   assign busy      = s1_valid_q || s2_valid_q;
   assign op_cnt    = op_cnt_q;
endmodule
